// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter with baud divider, parity and valid/ready input
//
// Purpose: serialises one DATA_BITS word per frame onto an idle-high line:
//    start(0), data LSB first, optional parity, STOP_BITS stop bits(1),
//    each bit held for CLK_DIV clock cycles.
// Ports:
//    clk       in   1          single clock, posedge
//    reset_n   in   1          asynchronous active-low reset
//    tx_valid  in   1          producer has a word on tx_data
//    tx_data   in   DATA_BITS  payload, LSB first
//    tx_ready  out  1          word accepted on this cycle's posedge if tx_valid
//    tx        out  1          serial line, straight from a flop
//    busy      out  1          frame in progress (inverse of tx_ready)
module uart_tx_param #(
   parameter int CLK_DIV    = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy
);

   // Guarded widths keep elaboration sane long enough for the checks below to report.
   localparam int BW = (CLK_DIV >= 2) ? $clog2(CLK_DIV) : 1;
   localparam int CW = $clog2(DATA_BITS + 1);

   localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
   localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

   generate
      if (CLK_DIV < 2) begin : g_bad_clk_div
         $error("uart_tx_param: CLK_DIV must be >= 2");
      end
      if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
         $error("uart_tx_param: DATA_BITS must be 5..9");
      end
      if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
         $error("uart_tx_param: STOP_BITS must be 1 or 2");
      end
      if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_parity_en
         $error("uart_tx_param: PARITY_EN must be 0 or 1");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [BW-1:0]        r_baud;
   logic [CW-1:0]        r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] w_shift_next;
   logic                 r_parity;
   logic                 r_tx;
   logic                 w_tx_next;
   logic                 w_accept;
   logic                 w_bit_end;

   assign w_accept  = tx_valid && (r_state == S_IDLE);
   assign w_bit_end = (r_baud == BAUD_LAST);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; every exit from a serial bit happens on a baud boundary
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_state_next = S_START;
         S_START:  if (w_bit_end) w_state_next = S_DATA;
         S_DATA:   if (w_bit_end && r_bit_cnt == DATA_LAST)
                      w_state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
         S_PARITY: if (w_bit_end) w_state_next = S_STOP;
         S_STOP:   if (w_bit_end && r_bit_cnt == STOP_LAST) w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   // Output logic: the line value is computed for the state being entered so the
   // tx flop lines up with the state register (start bit appears the cycle after accept).
   always_comb begin
      w_shift_next = r_shift;
      if (w_accept) begin
         w_shift_next = tx_data;
      end else if (r_state == S_DATA && w_bit_end) begin
         w_shift_next = r_shift >> 1;
      end
      case (w_state_next)
         S_START:  w_tx_next = 1'b0;
         S_DATA:   w_tx_next = w_shift_next[0];
         S_PARITY: w_tx_next = r_parity;
         default:  w_tx_next = 1'b1;
      endcase
   end

   // Datapath: baud/bit counters, shift register, parity and the line flop
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_baud    <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_parity  <= 1'b0;
         r_tx      <= 1'b1;
      end else begin
         r_shift <= w_shift_next;
         r_tx    <= w_tx_next;
         if (w_accept) begin
            // Parity taken from the word as latched; later tx_data changes cannot affect it.
            r_parity <= (^tx_data) ^ (PARITY_ODD != 0);
         end
         if (w_state_next != r_state) begin
            r_baud    <= '0;
            r_bit_cnt <= '0;
         end else if (r_state != S_IDLE) begin
            r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
            if (w_bit_end && (r_state == S_DATA || r_state == S_STOP)) begin
               r_bit_cnt <= r_bit_cnt + 1'b1;
            end
         end
      end
   end

   assign tx       = r_tx;
   assign tx_ready = (r_state == S_IDLE);
   assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - self-checking bench for uart_tx_param over four parameter sets
module tb_uart_tx_param;

   // Configurations: 0 = 8N1/4, 1 = 8E1/4, 2 = 8O1/3, 3 = 7N2/2
   localparam int CD[4] = '{4, 4, 3, 2};
   localparam int DB[4] = '{8, 8, 8, 7};
   localparam int PE[4] = '{0, 1, 1, 0};
   localparam int PO[4] = '{0, 0, 1, 0};
   localparam int SB[4] = '{1, 1, 1, 2};

   logic       clk = 1'b0;
   logic       reset_n;
   logic       vld [4];
   logic [8:0] dat [4];
   logic       rdy [4];
   logic       txo [4];
   logic       bsy [4];

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
      .clk(clk), .reset_n(reset_n), .tx_valid(vld[0]), .tx_data(dat[0][7:0]),
      .tx_ready(rdy[0]), .tx(txo[0]), .busy(bsy[0]));
   uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
      .clk(clk), .reset_n(reset_n), .tx_valid(vld[1]), .tx_data(dat[1][7:0]),
      .tx_ready(rdy[1]), .tx(txo[1]), .busy(bsy[1]));
   uart_tx_param #(.CLK_DIV(3), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
      .clk(clk), .reset_n(reset_n), .tx_valid(vld[2]), .tx_data(dat[2][7:0]),
      .tx_ready(rdy[2]), .tx(txo[2]), .busy(bsy[2]));
   uart_tx_param #(.CLK_DIV(2), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_7n2 (
      .clk(clk), .reset_n(reset_n), .tx_valid(vld[3]), .tx_data(dat[3][6:0]),
      .tx_ready(rdy[3]), .tx(txo[3]), .busy(bsy[3]));

   function automatic int frame_len(int k);
      return (1 + DB[k] + PE[k] + SB[k]) * CD[k];
   endfunction

   // Expected line level c cycles into a frame carrying word w (already masked to DB bits).
   function automatic logic exp_tx(int k, int w, int c);
      int b;
      b = c / CD[k];
      if (b == 0) return 1'b0;
      if (b <= DB[k]) return 1'((w >> (b - 1)) & 1);
      if (PE[k] != 0 && b == DB[k] + 1) return 1'(($countones(w) % 2) ^ PO[k]);
      return 1'b1;
   endfunction

   task automatic chk(string tag, logic obs, logic exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(int k, string tag);
      chk($sformatf("%s_ready[%0d]", tag, k), rdy[k], 1'b1);
      chk($sformatf("%s_tx[%0d]", tag, k), txo[k], 1'b1);
      chk($sformatf("%s_busy[%0d]", tag, k), bsy[k], 1'b0);
   endtask

   // Called at a negedge with instance k idle. Presents word, lets it be accepted on the
   // next posedge, then checks every frame cycle. hold keeps tx_valid high afterwards;
   // next_data replaces tx_data right after accept; pulse_at pulses tx_valid mid-frame;
   // rst_at asserts reset at that frame cycle and returns once reset is released.
   task automatic send(int k, int word, bit hold, int next_data, int pulse_at, int rst_at);
      int f;
      int w;
      f = frame_len(k);
      w = word & ((1 << DB[k]) - 1);
      vld[k] = 1'b1;
      dat[k] = 9'(word);
      chk_idle(k, "pre_accept");
      @(posedge clk);
      #1;
      if (!hold) vld[k] = 1'b0;
      dat[k] = 9'(next_data);
      for (int c = 0; c < f; c++) begin
         @(negedge clk);
         chk($sformatf("tx[%0d] w=%0h c=%0d", k, w, c), txo[k], exp_tx(k, w, c));
         chk($sformatf("ready_low[%0d] c=%0d", k, c), rdy[k], 1'b0);
         chk($sformatf("busy_high[%0d] c=%0d", k, c), bsy[k], 1'b1);
         if (c == pulse_at) begin
            vld[k] = 1'b1;
            dat[k] = 9'($urandom);
         end
         if (c == pulse_at + 1) vld[k] = 1'b0;
         if (c == rst_at) begin
            reset_n = 1'b0;
            #1;
            chk_idle(k, "async_reset");
            @(negedge clk);
            chk_idle(k, "in_reset");
            reset_n = 1'b1;
            return;
         end
      end
      @(negedge clk);
      chk_idle(k, "post_frame");
   endtask

   initial begin
      int w;
      int nxt;
      reset_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
         vld[k] = 1'b0;
         dat[k] = '0;
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < 4; k++) chk_idle(k, "reset");
      reset_n = 1'b1;
      @(negedge clk);

      // 8N1, 0xA5
      send(0, 'hA5, 1'b0, $urandom, -1, -1);
      // back-to-back with tx_valid held: 0x22 only sampled at second accept
      send(0, 'h11, 1'b1, 'h22, -1, -1);
      send(0, 'h22, 1'b0, $urandom, -1, -1);
      // tx_valid pulsed while busy must not produce another frame
      send(0, 'h5A, 1'b0, $urandom, 10, -1);
      for (int i = 0; i < 2 * frame_len(0); i++) begin
         @(negedge clk);
         chk($sformatf("no_extra_frame_tx i=%0d", i), txo[0], 1'b1);
         chk($sformatf("no_extra_frame_ready i=%0d", i), rdy[0], 1'b1);
      end
      // reset during data bit 3, then a clean frame
      send(0, 'h96, 1'b0, $urandom, -1, (1 + 3) * CD[0] + 1);
      send(0, 'h3C, 1'b0, $urandom, -1, -1);

      // parity cases and 7-bit / 2-stop frame
      send(1, 'h07, 1'b0, $urandom, -1, -1);
      send(1, 'h00, 1'b0, $urandom, -1, -1);
      send(2, 'h07, 1'b0, $urandom, -1, -1);
      send(2, 'h00, 1'b0, $urandom, -1, -1);
      send(3, 'h55, 1'b0, $urandom, -1, -1);

      // randomized words, mostly back-to-back, on every configuration
      for (int k = 0; k < 4; k++) begin
         w = int'($urandom);
         for (int i = 0; i < 6; i++) begin
            nxt = int'($urandom);
            send(k, w, i < 5, nxt, -1, -1);
            w = nxt;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
